// File: rtl/buffer_skew_feeder.sv
// Reads N consecutive buffer rows and replays them to the array's west edge as a diagonal
// wavefront: lane k of every row is delayed k cycles relative to lane 0.
module buffer_skew_feeder #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 128,
    parameter int LANES  = 8,
    parameter int LANE_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_cnt,
    output logic              busy,
    output logic              done,
    output logic              buf_CEN,
    output logic              buf_WEN,
    output logic              buf_RETN,
    output logic [ADDR_W-1:0] buf_A,
    input  logic [DATA_W-1:0] buf_Q,
    output logic [DATA_W-1:0] row_out,
    output logic [LANES-1:0]  lane_valid
);

    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cen_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W-1:0] rd_cnt_reg;
    logic [CNT_W-1:0]  drain_cnt_reg;
    logic              q_vld_reg;

    // Burst sequencer. FIN holds busy for the done cycle so a start there is ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cen_reg       <= 1'b1;
            addr_reg      <= '0;
            n_reg         <= '0;
            rd_cnt_reg    <= '0;
            drain_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        n_reg    <= row_cnt;
                        if (row_cnt == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            cen_reg    <= 1'b0;
                            addr_reg   <= base_addr;
                            rd_cnt_reg <= ADDR_W'(1);
                            state_reg  <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_cnt_reg == n_reg) begin
                        cen_reg       <= 1'b1;
                        drain_cnt_reg <= '0;
                        state_reg     <= DRAIN;
                    end else begin
                        addr_reg   <= addr_reg + ADDR_W'(1);
                        rd_cnt_reg <= rd_cnt_reg + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == CNT_W'(LANES - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
                    end
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data arrives the cycle after each enabled edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_vld_reg <= 1'b0;
        end else begin
            q_vld_reg <= ~cen_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] dline_reg [0:gi];
            logic [gi:0]       vline_reg;

            // Lane gi delay line of depth gi+1; data is zeroed when not valid.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int j = 0; j <= gi; j++) begin
                        dline_reg[j] <= '0;
                    end
                    vline_reg <= '0;
                end else begin
                    dline_reg[0] <= q_vld_reg ? buf_Q[gi*LANE_W +: LANE_W] : '0;
                    vline_reg[0] <= q_vld_reg;
                    for (int j = 1; j <= gi; j++) begin
                        dline_reg[j] <= dline_reg[j-1];
                        vline_reg[j] <= vline_reg[j-1];
                    end
                end
            end

            assign row_out[gi*LANE_W +: LANE_W] = dline_reg[gi];
            assign lane_valid[gi]               = vline_reg[gi];
        end
    endgenerate

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign buf_CEN  = cen_reg;
    assign buf_A    = addr_reg;
    assign buf_WEN  = 1'b1;
    assign buf_RETN = ~RST;

endmodule
